// File: rtl/pixel_array_ctrl_if.sv
// pixel_array_ctrl_if: Wishbone slave bus bundle between the Caravel bus and pixel_array_ctrl
interface pixel_array_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl: Wishbone-mapped LOC/ADJ/SH scan sequencer for N_PIX pixels; define PXL_IRQ_EN to add irq_o and CTRL[4] IRQ_ENA
module pixel_array_ctrl #(
  parameter int         N_PIX    = 4,
  parameter int         TIMER_W  = 10,
  parameter logic [3:0] BASE_NIB = 4'd3
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  pixel_array_ctrl_if.slave        wb,
  input  logic                     ext_start_i,
  output logic [N_PIX-1:0]         pxl_sel_o,
  output logic [$clog2(N_PIX)-1:0] pxl_idx_o,
  output logic                     s1_o,
  output logic                     s2_o,
  output logic                     sh_o,
  output logic                     busy_o,
  output logic                     frame_done_o
`ifdef PXL_IRQ_EN
  ,
  output logic                     irq_o
`endif
);
  typedef enum logic [2:0] {IDLE, LOC, ADJ, SH, NEXT} state_t;
  localparam int IW = $clog2(N_PIX);
  localparam logic [IW-1:0] LAST = IW'(N_PIX - 1);
  state_t state, nxt_state;
  logic [IW-1:0] idx, nxt_idx;
  logic [TIMER_W-1:0] tmr, nxt_tmr, loc_max, adj_max, loc_sh, adj_sh;
  logic [7:0] frame_cnt;
  logic [1:0] ra;
  logic [31:0] wmask, loc_wr, adj_wr, ctrl_rd, status_rd, rd;
  logic cont, src, irq_ena, done_sticky, ext_d;
  logic hit, wr, ctrl_wr, start, abort, trig, fend, clr;
  logic unused_bits;
`ifdef PXL_IRQ_EN
  localparam bit IRQ = 1'b1;
  assign irq_o = done_sticky & irq_ena;
`else
  localparam bit IRQ = 1'b0;
`endif
  assign hit = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:28] == BASE_NIB) & ~wb.wbs_ack_o;
  assign ra = wb.wbs_adr_i[3:2];
  assign wr = hit & wb.wbs_we_i;
  assign ctrl_wr = wr & (ra == 2'd0) & wb.wbs_sel_i[0];
  assign start = ctrl_wr & wb.wbs_dat_i[0];
  assign abort = ctrl_wr & wb.wbs_dat_i[2];
  assign clr = IRQ & wr & (ra == 2'd3) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
  assign trig = (state == IDLE) & (src ? ext_start_i & ~ext_d : start);
  assign fend = (state == SH) & (idx == LAST) & ~abort;
  assign wmask = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}}, {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
  assign loc_wr = (32'(loc_max) & ~wmask) | (wb.wbs_dat_i & wmask);
  assign adj_wr = (32'(adj_max) & ~wmask) | (wb.wbs_dat_i & wmask);
  assign ctrl_rd = {27'd0, irq_ena, src, 1'b0, cont, 1'b0};
  assign status_rd = {8'd0, 8'(idx), frame_cnt, 6'd0, done_sticky, busy_o};
  assign rd = ra == 2'd0 ? ctrl_rd : ra == 2'd1 ? 32'(loc_max) : ra == 2'd2 ? 32'(adj_max) : status_rd;
  assign unused_bits = ^{wb.wbs_adr_i[27:4], wb.wbs_adr_i[1:0], loc_wr, adj_wr};
  always_comb begin
    nxt_state = state;
    nxt_idx = idx;
    nxt_tmr = tmr;
    case (state)
      IDLE: if (trig) begin
        nxt_state = LOC;
        nxt_idx = '0;
        nxt_tmr = '0;
      end
      LOC: begin
        nxt_state = tmr == loc_sh ? ADJ : LOC;
        nxt_tmr = tmr == loc_sh ? '0 : tmr + TIMER_W'(1);
      end
      ADJ: begin
        nxt_state = tmr == adj_sh ? SH : ADJ;
        nxt_tmr = tmr == adj_sh ? '0 : tmr + TIMER_W'(1);
      end
      SH: nxt_state = NEXT;
      NEXT: begin
        nxt_state = (idx != LAST || cont) ? LOC : IDLE;
        nxt_idx = idx != LAST ? idx + IW'(1) : '0;
      end
      default: nxt_state = IDLE;
    endcase
    if (abort) begin
      nxt_state = IDLE;
      nxt_idx = '0;
      nxt_tmr = '0;
    end
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      idx <= '0;
      tmr <= '0;
      loc_max <= '0;
      adj_max <= '0;
      loc_sh <= '0;
      adj_sh <= '0;
      frame_cnt <= '0;
      cont <= 1'b0;
      src <= 1'b0;
      irq_ena <= 1'b0;
      done_sticky <= 1'b0;
      ext_d <= 1'b0;
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      s1_o <= 1'b0;
      s2_o <= 1'b0;
      sh_o <= 1'b0;
      busy_o <= 1'b0;
      frame_done_o <= 1'b0;
      pxl_sel_o <= '0;
      pxl_idx_o <= '0;
    end else begin
      wb.wbs_ack_o <= hit;
      if (hit) wb.wbs_dat_o <= rd;
      ext_d <= ext_start_i;
      if (ctrl_wr) begin
        cont <= wb.wbs_dat_i[1];
        src <= wb.wbs_dat_i[3];
        irq_ena <= IRQ & wb.wbs_dat_i[4];
      end
      if (wr && ra == 2'd1) loc_max <= loc_wr[TIMER_W-1:0];
      if (wr && ra == 2'd2) adj_max <= adj_wr[TIMER_W-1:0];
      state <= nxt_state;
      idx <= nxt_idx;
      tmr <= nxt_tmr;
      if (nxt_state == LOC && state != LOC) loc_sh <= loc_max;
      if (nxt_state == ADJ && state != ADJ) adj_sh <= adj_max;
      if (fend) frame_cnt <= frame_cnt + 8'd1;
      done_sticky <= fend | (done_sticky & ~trig & ~clr);
      s1_o <= nxt_state == LOC;
      s2_o <= nxt_state == ADJ;
      sh_o <= nxt_state == SH;
      busy_o <= nxt_state != IDLE;
      frame_done_o <= fend;
      pxl_sel_o <= nxt_state != IDLE ? N_PIX'(1) << nxt_idx : '0;
      pxl_idx_o <= nxt_idx;
    end
  end
endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb_pixel_array_ctrl: scoreboard bench for pixel_array_ctrl (N_PIX=4, TIMER_W=10)
module tb_pixel_array_ctrl;
  localparam logic [31:0] B = 32'h3000_0000;
  typedef struct { logic chk; logic [31:0] exp; } wb_t;
  typedef struct { int code; int len; logic [3:0] sel; } ph_t;
  logic clk = 1'b0, rst = 1'b1, ext = 1'b0;
  logic [3:0] sel;
  logic [1:0] idx;
  logic s1, s2, sh, busy, fd;
`ifdef PXL_IRQ_EN
  logic irq;
`endif
  wb_t wb_q[$];
  ph_t ph_q[$];
  int fd_q[$];
  int tests = 0, fails = 0, cyc_n = 0, ovl = 0, last_hit = 0;
  int cur_code = 0, cur_len = 0;
  logic [3:0] cur_sel = '0;
  pixel_array_ctrl_if bus ();
  pixel_array_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus), .ext_start_i(ext),
    .pxl_sel_o(sel), .pxl_idx_o(idx), .s1_o(s1), .s2_o(s2), .sh_o(sh),
    .busy_o(busy), .frame_done_o(fd)
`ifdef PXL_IRQ_EN
    , .irq_o(irq)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_n);
    end
  endtask
  task automatic wb_acc(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] bsel, input logic hit_exp, input logic [31:0] rexp);
    int got = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = bsel;
    if (hit_exp) wb_q.push_back('{!we, rexp});
    for (int n = 1; n <= 4 && got == 0; n++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        got = n;
        last_hit = cyc_n;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i = 1'b0;
    check("ack_latency", got, hit_exp ? 1 : 0);
    @(posedge clk); #1;
  endtask
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] bsel = 4'hf);
    wb_acc(1'b1, adr, dat, bsel, 1'b1, '0);
  endtask
  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp);
    wb_acc(1'b0, adr, '0, 4'hf, 1'b1, exp);
  endtask
  task automatic push_frame(input int lf, input int lr, input int a, input int np);
    for (int p = 0; p < np; p++) begin
      ph_q.push_back('{1, p == 0 ? lf : lr, 4'(1 << p)});
      ph_q.push_back('{2, a, 4'(1 << p)});
      ph_q.push_back('{3, 1, 4'(1 << p)});
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(n < 400), 32'd1);
  endtask
  task automatic wait_until(input int t);
    while (cyc_n < t) begin
      @(posedge clk); #1;
    end
  endtask
  always @(negedge clk) begin
    int code;
    ph_t e;
    wb_t w;
    if (!rst) begin
      code = s1 ? 1 : s2 ? 2 : sh ? 3 : 0;
      if (int'(s1) + int'(s2) + int'(sh) > 1) ovl++;
      if (code != cur_code) begin
        if (cur_code != 0) begin
          if (ph_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_phase: code %0d len %0d sel %b, none expected", cur_code, cur_len, cur_sel);
          end else begin
            e = ph_q.pop_front();
            check("phase code/len/sel", {4'(cur_code), 8'(cur_len), 16'd0, cur_sel}, {4'(e.code), 8'(e.len), 16'd0, e.sel});
          end
        end
        cur_code = code;
        cur_len = 1;
        cur_sel = sel;
      end else if (code != 0) cur_len++;
      if (fd) begin
        if (fd_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame_done at cycle %0d", cyc_n);
        end else check("frame_done_cycle", cyc_n, fd_q.pop_front());
      end
      if (bus.wbs_ack_o) begin
        if (wb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack at cycle %0d", cyc_n);
        end else begin
          w = wb_q.pop_front();
          if (w.chk) check("rdata", bus.wbs_dat_o, w.exp);
        end
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int h, t0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_adr_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({s1, s2, sh, busy, fd, sel, idx, bus.wbs_ack_o}), 32'd0);
    check("reset_dat_o", bus.wbs_dat_o, 32'd0);
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) wb_read(B + 32'(4 * r), 32'd0);
    wb_acc(1'b0, 32'h2000_0000, '0, 4'hf, 1'b0, '0);
    wb_write(B + 4, 32'hffff_ffff);
    wb_read(B + 4, 32'h3ff);
    wb_write(B + 4, 32'd3);
    wb_read(B + 4, 32'd3);
    wb_write(B + 8, 32'd2);
    wb_write(B + 8, 32'h0000_0100, 4'h2);
    wb_read(B + 8, 32'h102);
    wb_write(B + 8, 32'd2);
    // single frame
    push_frame(4, 4, 3, 4);
    wb_write(B, 32'h1);
    fd_q.push_back(last_hit + 35);
    wait_idle();
    wb_read(B + 12, 32'h0000_0102);
    // continuous, then CONT cleared during the second frame
    push_frame(4, 4, 3, 4);
    push_frame(4, 4, 3, 4);
    wb_write(B, 32'h3);
    h = last_hit;
    fd_q.push_back(h + 35);
    fd_q.push_back(h + 71);
    wait_until(h + 40);
    wb_write(B, 32'h0);
    wait_idle();
    wb_read(B + 12, 32'h0000_0302);
    // START while busy is dropped; ABORT lands in the first ADJ cycle of pixel 2
    push_frame(4, 4, 3, 2);
    ph_q.push_back('{1, 4, 4'b0100});
    ph_q.push_back('{2, 1, 4'b0100});
    wb_write(B, 32'h1);
    h = last_hit;
    wait_until(h + 9);
    wb_write(B, 32'h1);
    wait_until(h + 22);
    wb_write(B, 32'h4);
    check("abort_idle busy/sel", 32'({busy, sel}), 32'd0);
    wb_read(B + 12, 32'h0000_0300);
    // external start held 10 cycles; LOC_MAX shrunk during pixel 0 LOC
    wb_write(B, 32'h8);
    push_frame(4, 1, 3, 4);
    ext = 1'b1;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 ext = 1'b0;
      end
      begin
        @(posedge clk); #1;
        t0 = cyc_n;
        fd_q.push_back(t0 + 26);
        wb_write(B + 4, 32'd0);
      end
    join
    wait_idle();
    wb_write(B + 4, 32'd3);
    wb_read(B + 12, 32'h0000_0402);
`ifdef PXL_IRQ_EN
    wb_write(B, 32'h10);
    check("irq_set", 32'(irq), 32'd1);
    wb_read(B, 32'h10);
    wb_write(B + 12, 32'h2);
    check("irq_clear", 32'(irq), 32'd0);
    wb_read(B + 12, 32'h0000_0400);
`else
    wb_write(B + 12, 32'hffff_ffff);
    wb_read(B + 12, 32'h0000_0402);
    wb_write(B, 32'h10);
    wb_read(B, 32'h0);
`endif
    repeat (40) @(posedge clk);
    #1;
    check("phase_queue_empty", ph_q.size(), 32'd0);
    check("frame_done_queue_empty", fd_q.size(), 32'd0);
    check("wb_queue_empty", wb_q.size(), 32'd0);
    check("switch_overlap_cycles", ovl, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
